exec_alu_unit: RTL and testbench
================================

# exec_alu_unit

Parametrised RV32I/RV32M execute unit: decodes opcode/funct3/funct7, selects operands, and produces the integer result and branch condition. It replaces the single-cycle combinational ALU-control/ALU pair in the datapath's execute stage. Single-cycle ops finish in one cycle; multiply/divide iterate over XLEN cycles behind a valid/ready handshake.

## Interface
- XLEN, 32, datapath width; must be a power of two ≥ 8; SH = log2(XLEN)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept; high only in IDLE
- opcode  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7  input  7  instruction[31:25]
- rs1_data  input  XLEN  operand A
- rs2_data  input  XLEN  operand B (register form, branches)
- imm  input  XLEN  sign-extended immediate
- out_valid  output  1  result/bcond/illegal valid
- out_ready  input  1  consumer takes result
- result  output  XLEN  computed value
- bcond  output  1  branch taken (BRANCH ops only, else 0)
- illegal  output  1  unrecognised/unsupported encoding

## Operation
- Accept when in_valid && in_ready; all inputs captured into internal registers that cycle; inputs are don't-care afterwards.
- Operand B = imm for ARITHMETIC_IMM (0010011), LOAD (0000011), STORE (0100011); rs2_data otherwise.
- ARITHMETIC (0110011), funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7 0100000: SUB (f3=000), SRA (f3=101); other funct7 (except 0000001) → illegal.
- ARITHMETIC_IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (SRAI when funct7=0100000). No SUBI.
- Shifts use operand B[SH-1:0] only. SLT/SLTU result is zero-extended 0/1.
- BRANCH (1100011): bcond for BEQ/BNE/BLT/BGE/BLTU/BGEU (signed/unsigned per funct3); result = rs1−rs2; f3 010/011 → illegal.
- LOAD/STORE: result = rs1_data + imm (address).
- ARITHMETIC funct7 0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. MUL = low XLEN of 2·XLEN product; MULH* = high XLEN with per-op signedness. Multiply: shift-add on magnitudes, sign fixed at end. Divide: restoring, magnitudes, quotient sign = sA^sB, remainder sign = sA.
- Divide by zero: quotient = all ones, remainder = dividend. Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0. Both special cases bypass iteration.
- Any other opcode → illegal=1, result=0, bcond=0.
- FSM: IDLE → (accept, single-cycle or special case) DONE; IDLE → (accept, mul/div) BUSY; BUSY → DONE when iteration counter reaches XLEN−1; DONE → IDLE when out_ready, else hold.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, bcond=0, illegal=0, counter=0.
- Single-cycle ops, illegal, div special cases: accept in cycle T, out_valid=1 from T+1.
- Mul/div: accept in T, out_valid=1 from T+XLEN+1 (XLEN BUSY cycles).
- out_valid, result, bcond, illegal stable while out_valid && !out_ready; out_valid drops cycle after handshake; in_ready rises same cycle (back-to-back accepts allowed at one op every 2 cycles for single-cycle ops).
- in_ready=0 in BUSY and DONE; in_valid ignored there.
- reset asserted in any state (incl. mid-iteration) returns to reset values next edge; partial product/quotient discarded.

## Configuration
- MEXT_EN defined: M-extension decoded and iterative mul/div datapath instantiated as above.
- MEXT_EN undefined: no multiplier/divider logic, no BUSY state; funct7=0000001 ARITHMETIC ops → illegal=1, result=0, 1-cycle latency.

## Test plan
- Reset, then ADD rs1=5, rs2=7 (XLEN=32) -> out_valid at T+1, result=12, illegal=0; hold out_ready=0 3 cycles -> outputs stable.
- SRAI rs1=0x80000000, imm=0x404 (funct7=0100000, shamt 4) -> result=0xF8000000; SRLI same -> 0x08000000.
- BLT rs1=0xFFFFFFFF, rs2=1 -> bcond=1; BLTU same -> bcond=0.
- MULH rs1=0x80000000, rs2=0x80000000 (MEXT_EN) -> out_valid at T+33, result=0x40000000; MUL same -> 0.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x80000000 at T+1; DIVU by 0 -> 0xFFFFFFFF; REM 7/0 -> 7.
- Start DIVU 100/7, assert reset at T+10 -> IDLE, in_ready=1, out_valid=0 next cycle; new ADD then completes correctly. Without MEXT_EN, MUL -> illegal=1, result=0 at T+1.

Source files
------------

// File: rtl/exec_alu_unit.sv
// RV32I/RV32M execute unit: decode, operand select, single-cycle ALU and branch compare,
// plus an iterative shift-add multiplier / restoring divider built only when MEXT_EN is defined.
module exec_alu_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            bcond,
  output logic            illegal
);

  localparam int unsigned SH = $clog2(XLEN);
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef MEXT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

  state_t state, state_next;

  logic [XLEN-1:0] result_q;
  logic            bcond_q;
  logic            illegal_q;

  logic [XLEN-1:0] op_b, alu_res, sum, diff;
  logic [SH-1:0]   shamt;
  logic            lt_s, lt_u, alu_bcond, alu_illegal, is_muldiv;

  always_comb begin
    op_b = rs2_data;
    if (opcode == OP_IMM || opcode == OP_LOAD || opcode == OP_STORE)
      op_b = imm;
    shamt       = op_b[SH-1:0];
    sum         = rs1_data + op_b;
    diff        = rs1_data - op_b;
    lt_s        = $signed(rs1_data) < $signed(op_b);
    lt_u        = rs1_data < op_b;
    alu_res     = '0;
    alu_bcond   = 1'b0;
    alu_illegal = 1'b0;
    is_muldiv   = 1'b0;
    case (opcode)
      OP_ARITH: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  alu_res = sum;
            3'b001:  alu_res = rs1_data << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  alu_res = rs1_data ^ op_b;
            3'b101:  alu_res = rs1_data >> shamt;
            3'b110:  alu_res = rs1_data | op_b;
            default: alu_res = rs1_data & op_b;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_res = diff;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_res = XLEN'($signed(rs1_data) >>> shamt);
        end else if (funct7 == F7_MULDIV) begin
`ifdef MEXT_EN
          is_muldiv = 1'b1;
`else
          alu_illegal = 1'b1;
`endif
        end else begin
          alu_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        case (funct3)
          3'b000:  alu_res = sum;
          3'b001:  alu_res = rs1_data << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
          3'b100:  alu_res = rs1_data ^ op_b;
          3'b101:  alu_res = (funct7 == F7_ALT) ? XLEN'($signed(rs1_data) >>> shamt)
                                                : rs1_data >> shamt;
          3'b110:  alu_res = rs1_data | op_b;
          default: alu_res = rs1_data & op_b;
        endcase
      end
      OP_BRANCH: begin
        alu_res = diff;
        case (funct3)
          3'b000:  alu_bcond = (rs1_data == op_b);
          3'b001:  alu_bcond = (rs1_data != op_b);
          3'b100:  alu_bcond = lt_s;
          3'b101:  alu_bcond = !lt_s;
          3'b110:  alu_bcond = lt_u;
          3'b111:  alu_bcond = !lt_u;
          default: begin
            alu_res     = '0;
            alu_illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD, OP_STORE: alu_res = sum;
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef MEXT_EN
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] acc, acc_next, full;
  logic [XLEN-1:0]   opnd, mag_a, mag_b, md_special_res, md_res, quo, rem;
  logic [SH-1:0]     count;
  logic              md_div, md_neg_q, md_neg_r, md_hi;
  logic              a_signed, b_signed, sa, sb, div_zero, div_ovf, md_special;
  logic [XLEN:0]     sum_m, t_div, d_div;

  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa       = a_signed & rs1_data[XLEN-1];
    sb       = b_signed & rs2_data[XLEN-1];
    mag_a    = sa ? -rs1_data : rs1_data;
    mag_b    = sb ? -rs2_data : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);
    md_special     = div_zero | div_ovf;
    md_special_res = '0;
    if (div_zero)
      md_special_res = funct3[1] ? rs1_data : '1;
    else if (div_ovf)
      md_special_res = funct3[1] ? '0 : rs1_data;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum_m = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    t_div = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    d_div = t_div - {1'b0, opnd};
    if (md_div)
      acc_next = d_div[XLEN] ? {t_div[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                             : {d_div[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = {sum_m, acc[XLEN-1:1]};
    full = md_neg_q ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (md_div)
      md_res = md_hi ? (md_neg_r ? -rem : rem) : (md_neg_q ? -quo : quo);
    else
      md_res = md_hi ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      md_div   <= 1'b0;
      md_neg_q <= 1'b0;
      md_neg_r <= 1'b0;
      md_hi    <= 1'b0;
    end else if (state == IDLE && in_valid && is_muldiv) begin
      acc      <= {{XLEN{1'b0}}, mag_a};
      opnd     <= mag_b;
      count    <= '0;
      md_div   <= funct3[2];
      md_neg_q <= sa ^ sb;
      md_neg_r <= sa;
      md_hi    <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
    end else if (state == BUSY) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MEXT_EN
          state_next = (is_muldiv && !md_special) ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MEXT_EN
      BUSY: if (count == '1) state_next = DONE;
`endif
      default: if (out_ready) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      bcond_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
`ifdef MEXT_EN
      if (is_muldiv) begin
        result_q  <= md_special_res;
        bcond_q   <= 1'b0;
        illegal_q <= 1'b0;
      end else
`endif
      begin
        result_q  <= alu_res;
        bcond_q   <= alu_bcond;
        illegal_q <= alu_illegal;
      end
    end
`ifdef MEXT_EN
    else if (state == BUSY && count == '1) begin
      result_q <= md_res;
    end
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign bcond     = bcond_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed self-checking bench for exec_alu_unit (XLEN=32); mul/div cases build only with MEXT_EN.
module tb_exec_alu_unit;

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MD     = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        bcond;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] exp;
    logic        bc;
    logic        il;
    logic [7:0]  lat;
  } vec_t;

  exec_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .bcond(bcond), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Present one op, scramble inputs after acceptance, count negedges until out_valid.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input bit take, output logic [31:0] r, output logic bc,
                        output logic il, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    r = result; bc = bcond; il = illegal;
    if (take) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, bcond, illegal} !== 4'b1000 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b bc=%b il=%b res=%h, want 1 0 0 0 00000000",
               in_ready, out_valid, bcond, illegal, result);
    end
  endtask

  task automatic test_stall;
    logic [31:0] r; logic bc, il; int lat;
    run_op(OP_ARITH, 3'b000, 7'h00, 32'd5, 32'd7, 32'hFFFF_0000, 1'b0, r, bc, il, lat);
    checks++;
    if (lat !== 1 || r !== 32'd12 || il !== 1'b0 || bc !== 1'b0) begin
      errors++;
      $display("FAIL add: lat=%0d res=%h il=%b bc=%b, want 1 0000000c 0 0", lat, r, il, bc);
    end
    opcode = OP_ARITH; funct3 = 3'b000; funct7 = F7_ALT;
    rs1_data = 32'd9; rs2_data = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd12 || in_ready !== 1'b0 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b res=%h rdy=%b il=%b, want 1 0000000c 0 0",
                 i, out_valid, result, in_ready, illegal);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd5) begin
      errors++;
      $display("FAIL sub_after_stall: vld=%b res=%h, want 1 00000005", out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_vectors(input string name, input vec_t v[]);
    logic [31:0] r; logic bc, il; int lat;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].im, 1'b1, r, bc, il, lat);
      checks++;
      if (r !== v[i].exp || bc !== v[i].bc || il !== v[i].il || lat !== int'(v[i].lat)) begin
        errors++;
        $display("FAIL %s[%0d]: res=%h bc=%b il=%b lat=%0d, want %h %b %b %0d",
                 name, i, r, bc, il, lat, v[i].exp, v[i].bc, v[i].il, v[i].lat);
      end
    end
  endtask

  task automatic test_alu;
    vec_t v[];
    v = '{
      '{OP_ARITH, 3'b000, F7_ALT, 32'd5,         32'd7,         32'h0,     32'hFFFF_FFFE, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b001, 7'h00,  32'd1,         32'd33,        32'h0,     32'h0000_0002, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b010, 7'h00,  32'hFFFF_FFFF, 32'd1,         32'h0,     32'h0000_0001, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b011, 7'h00,  32'hFFFF_FFFF, 32'd1,         32'h0,     32'h0000_0000, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b100, 7'h00,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,     32'hFF00_FF00, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b101, 7'h00,  32'h8000_0000, 32'd4,         32'h0,     32'h0800_0000, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b101, F7_ALT, 32'h8000_0000, 32'd4,         32'h0,     32'hF800_0000, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b110, 7'h00,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,     32'hFFF0_FFF0, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b111, 7'h00,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,     32'h00F0_00F0, 1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b000, 7'h00,  32'd10,        32'd12345,     32'hFFFF_FFFF, 32'd9,     1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b010, 7'h00,  32'hFFFF_FFFE, 32'd0,         32'hFFFF_FFFF, 32'd1,     1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b011, 7'h00,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd1,     1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b100, 7'h00,  32'h0000_00FF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b110, 7'h00,  32'h0000_0100, 32'd0,         32'h0000_000F, 32'h0000_010F, 1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b111, 7'h00,  32'h0000_00FF, 32'd0,         32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b001, 7'h00,  32'd3,         32'd0,         32'd2,         32'd12,        1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b101, F7_ALT, 32'h8000_0000, 32'd0,         32'h0000_0404, 32'hF800_0000, 1'b0, 1'b0, 8'd1},
      '{OP_IMM,   3'b101, 7'h00,  32'h8000_0000, 32'd0,         32'h0000_0404, 32'h0800_0000, 1'b0, 1'b0, 8'd1},
      '{OP_LOAD,  3'b010, 7'h00,  32'h0000_1000, 32'd77,        32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0, 8'd1},
      '{OP_STORE, 3'b010, 7'h00,  32'h0000_0010, 32'd77,        32'd8,         32'h0000_0018, 1'b0, 1'b0, 8'd1}
    };
    test_vectors("alu", v);
  endtask

  task automatic test_branch;
    vec_t v[];
    v = '{
      '{OP_BRANCH, 3'b000, 7'h00, 32'd5,         32'd5, 32'd99, 32'h0000_0000, 1'b1, 1'b0, 8'd1},
      '{OP_BRANCH, 3'b001, 7'h00, 32'd5,         32'd5, 32'd99, 32'h0000_0000, 1'b0, 1'b0, 8'd1},
      '{OP_BRANCH, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,  32'hFFFF_FFFE, 1'b1, 1'b0, 8'd1},
      '{OP_BRANCH, 3'b101, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 8'd1},
      '{OP_BRANCH, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 8'd1},
      '{OP_BRANCH, 3'b111, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,  32'hFFFF_FFFE, 1'b1, 1'b0, 8'd1}
    };
    test_vectors("branch", v);
  endtask

  task automatic test_illegal;
    vec_t v[];
    v = '{
      '{7'b1111111, 3'b000, 7'h00,    32'd5, 32'd3, 32'd1, 32'h0, 1'b0, 1'b1, 8'd1},
      '{OP_BRANCH,  3'b010, 7'h00,    32'd5, 32'd3, 32'd1, 32'h0, 1'b0, 1'b1, 8'd1},
      '{OP_ARITH,   3'b000, 7'h02,    32'd5, 32'd3, 32'd1, 32'h0, 1'b0, 1'b1, 8'd1}
    };
    test_vectors("illegal", v);
  endtask

  task automatic test_mext;
    vec_t v[];
`ifdef MEXT_EN
    v = '{
      '{OP_ARITH, 3'b001, F7_MD, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b000, F7_MD, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b011, F7_MD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b010, F7_MD, 32'hFFFF_FFFF, 32'd2,         32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b100, F7_MD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b110, F7_MD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b101, F7_MD, 32'd7,         32'd0,         32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b110, F7_MD, 32'd7,         32'd0,         32'h0, 32'd7,         1'b0, 1'b0, 8'd1},
      '{OP_ARITH, 3'b100, F7_MD, 32'hFFFF_FFF9, 32'd2,         32'h0, 32'hFFFF_FFFD, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b110, F7_MD, 32'hFFFF_FFF9, 32'd2,         32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b101, F7_MD, 32'd100,       32'd7,         32'h0, 32'd14,        1'b0, 1'b0, 8'd33},
      '{OP_ARITH, 3'b111, F7_MD, 32'd100,       32'd7,         32'h0, 32'd2,         1'b0, 1'b0, 8'd33}
    };
`else
    v = '{
      '{OP_ARITH, 3'b000, F7_MD, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b1, 8'd1},
      '{OP_ARITH, 3'b101, F7_MD, 32'd100,       32'd7,         32'h0, 32'h0, 1'b0, 1'b1, 8'd1}
    };
`endif
    test_vectors("mext", v);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    opcode = OP_ARITH; funct3 = 3'b000; funct7 = 7'h00;
    rs1_data = 32'd1; rs2_data = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: vld=%b res=%h rdy=%b, want 1 00000002 0", out_valid, result, in_ready);
    end
    rs1_data = 32'd3; rs2_data = 32'd4;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd7) begin
      errors++;
      $display("FAIL b2b_second: vld=%b res=%h, want 1 00000007", out_valid, result);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop;
    logic [31:0] r; logic bc, il; int lat;
    run_op(OP_ARITH, 3'b000, 7'h00, 32'd1, 32'd2, 32'd0, 1'b0, r, bc, il, lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_done: vld=%b rdy=%b res=%h, want 0 1 00000000", out_valid, in_ready, result);
    end
`ifdef MEXT_EN
    opcode = OP_ARITH; funct3 = 3'b101; funct7 = F7_MD;
    rs1_data = 32'd100; rs2_data = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL divu_busy: vld=%b rdy=%b, want 0 0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy: vld=%b rdy=%b res=%h, want 0 1 00000000", out_valid, in_ready, result);
    end
`endif
    run_op(OP_ARITH, 3'b000, 7'h00, 32'd20, 32'd22, 32'd0, 1'b1, r, bc, il, lat);
    checks++;
    if (lat !== 1 || r !== 32'd42 || il !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: lat=%0d res=%h il=%b, want 1 0000002a 0", lat, r, il);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_stall();
    test_alu();
    test_branch();
    test_illegal();
    test_mext();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
